// File: rtl/sram_bus_responder.sv
// Memory-side responder: serves the core's byte bus from a 512Kx16 async SRAM.
// Latency: cached read hit 0 stall cycles; read miss or write WAIT+2 stall cycles.
// Backpressure: stalls the core through `ce`; the core retires an access on an edge with ce=1.
//
// Ports:
//   clock, reset_n       core clock, synchronous active-low reset
//   address/din/we       core byte access (address held stable while ce=0)
//   dout, ce             read byte and clock enable back to the core
//   sram_a/sram_d_i/sram_d_o/sram_dq_oe/sram_oe/sram_we/sram_lb/sram_ub
//                        SRAM pin-side controls (all active high here)
// Build option: define WORD_CACHE_EN to keep a one-word read cache in front of the SRAM.
module sram_bus_responder #(
    parameter int WAIT = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [19:0] address,
    input  logic [7:0]  din,
    input  logic        we,
    output logic [7:0]  dout,
    output logic        ce,
    output logic [18:0] sram_a,
    input  logic [15:0] sram_d_i,
    output logic [15:0] sram_d_o,
    output logic        sram_dq_oe,
    output logic        sram_oe,
    output logic        sram_we,
    output logic        sram_lb,
    output logic        sram_ub
);

    if (WAIT < 1 || WAIT > 15) begin : g_wait_range
        $error("sram_bus_responder: WAIT must be within 1..15");
    end

    localparam logic [3:0] CNT_INIT = 4'(WAIT - 1);

    // HOLD sits between the strobe phase and DONE: it keeps the data pins
    // driven one cycle after we falls (write hold time) and gives the bus a
    // turnaround cycle after oe falls on reads.
    typedef enum logic [2:0] {IDLE, RD, WR, HOLD, DONE} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic [15:0] rdata;
    logic        hit;
    logic [15:0] hit_word;

`ifdef WORD_CACHE_EN
    logic        valid;
    logic [18:0] tag;
    logic [15:0] word;

    // Fill on every completed SRAM read; a write only patches the cached
    // copy when it targets the cached word, otherwise the cache is left alone.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid <= 1'b0;
            tag   <= '0;
            word  <= '0;
        end else if (state == RD && cnt == 4'd0) begin
            valid <= 1'b1;
            tag   <= sram_a;
            word  <= sram_d_i;
        end else if (state == WR && cnt == 4'd0 && valid && tag == sram_a) begin
            if (sram_ub)
                word[15:8] <= sram_d_o[15:8];
            else
                word[7:0]  <= sram_d_o[7:0];
        end
    end

    assign hit      = valid && !we && (tag == address[19:1]);
    assign hit_word = word;
`else
    assign hit      = 1'b0;
    assign hit_word = 16'h0000;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ce       = 1'b0;
        dout     = 8'h00;
        case (state)
            IDLE: begin
                if (hit) begin
                    ce   = 1'b1;
                    dout = address[0] ? hit_word[15:8] : hit_word[7:0];
                end else if (we) begin
                    state_nx = WR;
                end else begin
                    state_nx = RD;
                end
            end
            RD:      if (cnt == 4'd0) state_nx = HOLD;
            WR:      if (cnt == 4'd0) state_nx = HOLD;
            HOLD:    state_nx = DONE;
            DONE: begin
                ce       = 1'b1;
                dout     = address[0] ? rdata[15:8] : rdata[7:0];
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (!reset_n) begin
            ce   = 1'b0;
            dout = 8'h00;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt        <= '0;
            rdata      <= '0;
            sram_a     <= '0;
            sram_d_o   <= '0;
            sram_dq_oe <= 1'b0;
            sram_oe    <= 1'b0;
            sram_we    <= 1'b0;
            sram_lb    <= 1'b0;
            sram_ub    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hit) begin
                        sram_a <= address[19:1];
                        cnt    <= CNT_INIT;
                        if (we) begin
                            sram_d_o   <= {din, din};
                            sram_dq_oe <= 1'b1;
                            sram_we    <= 1'b1;
                            sram_lb    <= ~address[0];
                            sram_ub    <= address[0];
                        end else begin
                            sram_oe <= 1'b1;
                            sram_lb <= 1'b1;
                            sram_ub <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (cnt == 4'd0) begin
                        rdata   <= sram_d_i;
                        sram_oe <= 1'b0;
                        sram_lb <= 1'b0;
                        sram_ub <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR: begin
                    if (cnt == 4'd0) begin
                        sram_we <= 1'b0;
                        sram_lb <= 1'b0;
                        sram_ub <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD:    sram_dq_oe <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
